motion_sequencer: RTL and testbench

Sequences the line-tracking drive datapath of the car. It turns the four active-low path-detector bits into registered per-wheel speed codes and direction controls. Sharp and edge turns are committed for a timed hold, line loss and obstacle stops are handled by a state machine, and manual drive runs while tracing is disabled. It sits between the sensor inputs and the PWM/H-bridge stage; its speed codes select among the shared 0/150/220/250/255 duty generators.

---
 rtl/smartcar_pkg.sv | 116 +++++++++++
 rtl/hold_timer.sv | 30 +++
 rtl/motion_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_motion_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/smartcar_pkg.sv
// Shared types and constants for the smart-car drive sequencer.
// States, track classes, speed/ctrl codes, LED patterns, drive helpers.
package smartcar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRACK     = 3'd1,
        ST_TURN_HOLD = 3'd2,
        ST_LOST      = 3'd3,
        ST_FAULT     = 3'd4,
        ST_OBST_STOP = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        TC_SHARP_R,
        TC_SHARP_L,
        TC_EDGE_L,
        TC_EDGE_R,
        TC_MILD_L,
        TC_MILD_R,
        TC_STRAIGHT,
        TC_LOST
    } track_t;

    localparam logic [2:0] SPD_0   = 3'd0;
    localparam logic [2:0] SPD_150 = 3'd1;
    localparam logic [2:0] SPD_220 = 3'd2;
    localparam logic [2:0] SPD_250 = 3'd3;
    localparam logic [2:0] SPD_255 = 3'd4;

    localparam logic [1:0] CTL_FWD = 2'b01;
    localparam logic [1:0] CTL_REV = 2'b10;
    localparam logic [1:0] CTL_BRK = 2'b00;

    localparam logic [3:0] LED_OFF      = 4'b0000;
    localparam logic [3:0] LED_SHARP_R  = 4'b0011;
    localparam logic [3:0] LED_SHARP_L  = 4'b1100;
    localparam logic [3:0] LED_EDGE_L   = 4'b1000;
    localparam logic [3:0] LED_EDGE_R   = 4'b0001;
    localparam logic [3:0] LED_MILD_L   = 4'b0100;
    localparam logic [3:0] LED_MILD_R   = 4'b0010;
    localparam logic [3:0] LED_STRAIGHT = 4'b0110;
    localparam logic [3:0] LED_LOST     = 4'b1111;
    localparam logic [3:0] LED_FAULT    = 4'b1111;
    localparam logic [3:0] LED_OBST     = 4'b1001;

    typedef struct packed {
        logic [2:0] spd1;
        logic [2:0] spd2;
        logic [1:0] ctl1;
        logic [1:0] ctl2;
        logic [3:0] led;
    } drive_t;

    localparam drive_t DRV_OBST  = {SPD_0, SPD_0, CTL_BRK, CTL_BRK, LED_OBST};
    localparam drive_t DRV_FAULT = {SPD_0, SPD_0, CTL_BRK, CTL_BRK, LED_FAULT};

    // Detector bits are active-low; the first matching rule wins.
    function automatic track_t classify(input logic [3:0] s);
        logic [3:0] v;
        v = ~s;
        if ((v[3] | v[2]) & v[0]) return TC_SHARP_R;
        if (v[3] & (v[1] | v[0])) return TC_SHARP_L;
        if (v[3]) return TC_EDGE_L;
        if (v[0]) return TC_EDGE_R;
        if (v[2] & ~v[1]) return TC_MILD_L;
        if (~v[2] & v[1]) return TC_MILD_R;
        if (v[2] & v[1]) return TC_STRAIGHT;
        return TC_LOST;
    endfunction

    function automatic drive_t pivot(
        input logic       left,
        input logic [2:0] spd,
        input logic [3:0] led
    );
        drive_t d;
        d.spd1 = spd;
        d.spd2 = spd;
        d.ctl1 = left ? CTL_REV : CTL_FWD;
        d.ctl2 = left ? CTL_FWD : CTL_REV;
        d.led  = led;
        return d;
    endfunction

    function automatic drive_t cruise(
        input logic [2:0] s1,
        input logic [2:0] s2,
        input logic [3:0] led
    );
        return {s1, s2, CTL_FWD, CTL_FWD, led};
    endfunction

    function automatic drive_t track_drive(input track_t tc);
        case (tc)
            TC_SHARP_R:  return pivot(1'b0, SPD_250, LED_SHARP_R);
            TC_SHARP_L:  return pivot(1'b1, SPD_250, LED_SHARP_L);
            TC_EDGE_L:   return pivot(1'b1, SPD_150, LED_EDGE_L);
            TC_EDGE_R:   return pivot(1'b0, SPD_150, LED_EDGE_R);
            TC_MILD_L:   return cruise(SPD_0, SPD_220, LED_MILD_L);
            TC_MILD_R:   return cruise(SPD_220, SPD_0, LED_MILD_R);
            TC_STRAIGHT: return cruise(SPD_255, SPD_255, LED_STRAIGHT);
            default:     return cruise(SPD_150, SPD_150, LED_LOST);
        endcase
    endfunction

    function automatic drive_t man_drive(input logic [1:0] cmd);
        unique case (cmd)
            2'b01:   return cruise(SPD_255, SPD_255, LED_OFF);
            2'b10:   return pivot(1'b1, SPD_150, LED_OFF);
            2'b11:   return pivot(1'b0, SPD_150, LED_OFF);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Millisecond down-counter for turn holds, line search and obstacle clear.
// A load always beats a decrement; expire pulses on the tick at count 1.
module hold_timer
    import smartcar_pkg::*;
#(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          tick,
    output logic          expire
);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = tick && !load && (count == TW'(1));

endmodule

// File: rtl/motion_sequencer.sv
// Line-tracking drive sequencer: sensors -> per-wheel speed/ctrl codes.
// Define LOST_SEARCH_EN for directional line search with FAULT timeout.
module motion_sequencer
    import smartcar_pkg::*;
#(
    parameter int HOLD_SHARP_MS = 80,
    parameter int HOLD_EDGE_MS  = 2,
    parameter int LOST_MS       = 200,
    parameter int CLEAR_MS      = 50,
    parameter int TW            = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1ms,
    input  logic       En_Tracing,
    input  logic [3:0] PathDectSignal,
    input  logic       obstacle,
    input  logic [1:0] man_cmd,
    output logic [2:0] speed_code_1,
    output logic [2:0] speed_code_2,
    output logic [1:0] Control_Wheel_1,
    output logic [1:0] Control_Wheel_2,
    output logic [3:0] Led_Direction,
    output logic [2:0] state_o
);

    localparam logic [TW-1:0] T_SHARP = TW'(HOLD_SHARP_MS);
    localparam logic [TW-1:0] T_EDGE  = TW'(HOLD_EDGE_MS);
    localparam logic [TW-1:0] T_LOST  = TW'(LOST_MS);
    localparam logic [TW-1:0] T_CLEAR = TW'(CLEAR_MS);

    logic [5:0]    sync1;
    logic [5:0]    sync2;
    logic          en_s;
    logic [3:0]    path_s;
    logic          obst_s;
    logic          seen;
    track_t        tc;
    drive_t        trk;
    drive_t        drv;
    state_t        state;
    logic          load;
    logic [TW-1:0] load_val;
    logic          expire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {En_Tracing, PathDectSignal, obstacle};
            sync2 <= sync1;
        end
    end

    assign en_s   = sync2[5];
    assign path_s = sync2[4:1];
    assign obst_s = sync2[0];
    assign seen   = ~&path_s;
    assign tc     = classify(path_s);

`ifdef LOST_SEARCH_EN
    logic dir;
    logic dir_nxt;

    always_comb begin
        dir_nxt = dir;
        case (tc)
            TC_SHARP_L, TC_EDGE_L, TC_MILD_L: dir_nxt = 1'b1;
            TC_SHARP_R, TC_EDGE_R, TC_MILD_R: dir_nxt = 1'b0;
            default: ;
        endcase
    end

    // Last heading is learnt only from decisions taken while tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir <= 1'b0;
        end else if (en_s && !obst_s && state == ST_TRACK) begin
            dir <= dir_nxt;
        end
    end

    always_comb begin
        trk = track_drive(tc);
        if (tc == TC_LOST) trk = pivot(dir, SPD_150, LED_LOST);
    end
`else
    assign trk = track_drive(tc);
`endif

    always_comb begin
        load     = 1'b0;
        load_val = '0;
        if (en_s) begin
            if (obst_s && state inside
                {ST_TRACK, ST_TURN_HOLD, ST_LOST, ST_OBST_STOP}) begin
                load     = 1'b1;
                load_val = T_CLEAR;
            end else if (state == ST_TRACK) begin
                case (tc)
                    TC_SHARP_R, TC_SHARP_L: begin
                        load     = 1'b1;
                        load_val = T_SHARP;
                    end
                    TC_EDGE_L, TC_EDGE_R: begin
                        load     = 1'b1;
                        load_val = T_EDGE;
                    end
                    TC_LOST: begin
                        load     = 1'b1;
                        load_val = T_LOST;
                    end
                    default: ;
                endcase
            end
        end
    end

    hold_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .tick     (tick_1ms),
        .expire   (expire)
    );

    // Every re-entry to TRACK already shows the decode of current sensors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            drv   <= '0;
        end else if (!en_s) begin
            state <= ST_IDLE;
            drv   <= man_drive(man_cmd);
        end else if (obst_s && state inside
                     {ST_TRACK, ST_TURN_HOLD, ST_LOST}) begin
            state <= ST_OBST_STOP;
            drv   <= DRV_OBST;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state <= ST_TRACK;
                    drv   <= trk;
                end
                ST_TRACK: begin
                    drv <= trk;
                    case (tc)
                        TC_SHARP_R, TC_SHARP_L,
                        TC_EDGE_L, TC_EDGE_R: state <= ST_TURN_HOLD;
                        TC_LOST:              state <= ST_LOST;
                        default:              state <= ST_TRACK;
                    endcase
                end
                ST_TURN_HOLD: begin
                    if (expire) begin
                        state <= ST_TRACK;
                        drv   <= trk;
                    end
                end
                ST_LOST: begin
                    if (seen) begin
                        state <= ST_TRACK;
                        drv   <= trk;
                    end
`ifdef LOST_SEARCH_EN
                    else if (expire) begin
                        state <= ST_FAULT;
                        drv   <= DRV_FAULT;
                    end
`endif
                end
                ST_OBST_STOP: begin
                    if (!obst_s && expire) begin
                        state <= ST_TRACK;
                        drv   <= trk;
                    end
                end
                ST_FAULT: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign speed_code_1    = drv.spd1;
    assign speed_code_2    = drv.spd2;
    assign Control_Wheel_1 = drv.ctl1;
    assign Control_Wheel_2 = drv.ctl2;
    assign Led_Direction   = drv.led;
    assign state_o         = state;

endmodule

// File: tb/tb_motion_sequencer.sv
// Scoreboard bench for motion_sequencer against a behavioural car model.
module tb_motion_sequencer;

    localparam int SHARP = 80;
    localparam int EDGE  = 2;
    localparam int LOSTT = 200;
    localparam int CLR   = 50;

    localparam int S_IDLE  = 0;
    localparam int S_TRACK = 1;
    localparam int S_HOLD  = 2;
    localparam int S_LOST  = 3;
    localparam int S_FAULT = 4;
    localparam int S_OBST  = 5;

    typedef struct packed {
        logic [2:0] c1;
        logic [2:0] c2;
        logic [1:0] w1;
        logic [1:0] w2;
        logic [3:0] led;
        logic [2:0] st;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1ms;
    logic       En_Tracing;
    logic [3:0] PathDectSignal;
    logic       obstacle;
    logic [1:0] man_cmd;
    logic [2:0] speed_code_1;
    logic [2:0] speed_code_2;
    logic [1:0] Control_Wheel_1;
    logic [1:0] Control_Wheel_2;
    logic [3:0] Led_Direction;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    motion_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick_1ms        (tick_1ms),
        .En_Tracing      (En_Tracing),
        .PathDectSignal  (PathDectSignal),
        .obstacle        (obstacle),
        .man_cmd         (man_cmd),
        .speed_code_1    (speed_code_1),
        .speed_code_2    (speed_code_2),
        .Control_Wheel_1 (Control_Wheel_1),
        .Control_Wheel_2 (Control_Wheel_2),
        .Led_Direction   (Led_Direction),
        .state_o         (state_o)
    );

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   phase = 0;

    // Reference car: input pipeline, mode, ms countdown, heading.
    logic [5:0] m_p1, m_p2;
    int         m_st, m_tmr;
    bit         m_left;
    obs_t       m_out;

    task automatic put(input int a, input int b, input int x,
                       input int y, input logic [3:0] led);
        m_out.c1  = 3'(a);
        m_out.c2  = 3'(b);
        m_out.w1  = 2'(x);
        m_out.w2  = 2'(y);
        m_out.led = led;
    endtask

    // Pivot: the inner wheel reverses (1=fwd, 2=rev).
    task automatic spin(input bit left, input int spd, input logic [3:0] led);
        if (left) put(spd, spd, 2, 1, led);
        else      put(spd, spd, 1, 2, led);
    endtask

    task automatic search_drive();
`ifdef LOST_SEARCH_EN
        spin(m_left, 1, 4'b1111);
`else
        put(1, 1, 1, 1, 4'b1111);
`endif
    endtask

    // kind: 0 keep tracking, 1 sharp hold, 2 edge hold, 3 line lost
    task automatic decode(input logic [3:0] p, input bit upd,
                          output int kind);
        bit l3, l2, l1, l0;
        l3 = !p[3]; l2 = !p[2]; l1 = !p[1]; l0 = !p[0];
        kind = 0;
        if ((l3 || l2) && l0) begin
            spin(0, 3, 4'b0011); kind = 1; if (upd) m_left = 0;
        end else if (l3 && (l1 || l0)) begin
            spin(1, 3, 4'b1100); kind = 1; if (upd) m_left = 1;
        end else if (l3) begin
            spin(1, 1, 4'b1000); kind = 2; if (upd) m_left = 1;
        end else if (l0) begin
            spin(0, 1, 4'b0001); kind = 2; if (upd) m_left = 0;
        end else if (l2 && !l1) begin
            put(0, 2, 1, 1, 4'b0100); if (upd) m_left = 1;
        end else if (!l2 && l1) begin
            put(2, 0, 1, 1, 4'b0010); if (upd) m_left = 0;
        end else if (l2 && l1) begin
            put(4, 4, 1, 1, 4'b0110);
        end else begin
            search_drive(); kind = 3;
        end
    endtask

    task automatic model_step(input bit r, input bit tk,
                              input logic [1:0] mc, input logic [5:0] raw);
        bit en, ob, due, loaded;
        logic [3:0] p;
        int kind;
        if (!r) begin
            m_p1 = '0; m_p2 = '0; m_st = S_IDLE; m_tmr = 0;
            m_left = 0; m_out = '0;
            return;
        end
        en = m_p2[5]; p = m_p2[4:1]; ob = m_p2[0];
        due = tk && (m_tmr == 1);
        loaded = 0;
        if (!en) begin
            m_st = S_IDLE;
            case (mc)
                2'b01:   put(4, 4, 1, 1, 4'b0000);
                2'b10:   spin(1, 1, 4'b0000);
                2'b11:   spin(0, 1, 4'b0000);
                default: put(0, 0, 0, 0, 4'b0000);
            endcase
        end else if (ob && (m_st == S_TRACK || m_st == S_HOLD ||
                            m_st == S_LOST || m_st == S_OBST)) begin
            put(0, 0, 0, 0, 4'b1001);
            m_st = S_OBST; m_tmr = CLR; loaded = 1;
        end else begin
            case (m_st)
                S_IDLE: begin decode(p, 0, kind); m_st = S_TRACK; end
                S_TRACK: begin
                    decode(p, 1, kind);
                    if (kind == 1) begin m_st = S_HOLD; m_tmr = SHARP; loaded = 1; end
                    if (kind == 2) begin m_st = S_HOLD; m_tmr = EDGE; loaded = 1; end
                    if (kind == 3) begin m_st = S_LOST; m_tmr = LOSTT; loaded = 1; end
                end
                S_HOLD: if (due) begin decode(p, 0, kind); m_st = S_TRACK; end
                S_LOST: begin
                    if (p != 4'hF) begin decode(p, 0, kind); m_st = S_TRACK; end
`ifdef LOST_SEARCH_EN
                    else if (due) begin put(0, 0, 0, 0, 4'b1111); m_st = S_FAULT; end
`endif
                end
                S_OBST: if (due) begin decode(p, 0, kind); m_st = S_TRACK; end
                default: ;
            endcase
        end
        if (!loaded && tk && m_tmr > 0) m_tmr--;
        m_p2 = m_p1;
        m_p1 = raw;
    endtask

    task automatic step(input bit r, input bit e, input logic [3:0] p,
                        input bit o, input logic [1:0] mc);
        @(negedge clk);
        rst_n = r; En_Tracing = e; PathDectSignal = p;
        obstacle = o; man_cmd = mc;
        tick_1ms = ((cyc % 4) == phase);
        cyc++;
        model_step(r, tick_1ms, mc, {e, p, o});
        m_out.st = 3'(m_st);
        exp_q.push_back(m_out);
    endtask

    task automatic run(input int n, input bit r, input bit e,
                       input logic [3:0] p, input bit o);
        for (int i = 0; i < n; i++)
            step(r, e, p, o, 2'($urandom_range(0, 3)));
    endtask

    always @(posedge clk) begin
        obs_t e, a;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {speed_code_1, speed_code_2, Control_Wheel_1,
                 Control_Wheel_2, Led_Direction, state_o};
            tests++;
            if (a !== e) begin
                fails++;
                if (fails <= 10)
                    $display("FAIL outputs @%0t: got c=%0d/%0d w=%b/%b led=%b st=%0d, want c=%0d/%0d w=%b/%b led=%b st=%0d",
                             $time, a.c1, a.c2, a.w1, a.w2, a.led, a.st,
                             e.c1, e.c2, e.w1, e.w2, e.led, e.st);
            end
        end
    end

    logic [3:0] pats [10] = '{4'b1001, 4'b1011, 4'b1101, 4'b1111,
                             4'b1010, 4'b0111, 4'b1110, 4'b0011,
                             4'b0101, 4'b1100};

    initial begin
        logic [3:0] sp;
        int len;
        phase = $urandom_range(0, 3);
        rst_n = 0; En_Tracing = 0; PathDectSignal = 4'hF;
        obstacle = 0; man_cmd = 0; tick_1ms = 0;

        run(3, 0, 0, 4'hF, 0);
        run(6, 1, 1, 4'b1001, 0);
        run(1, 1, 1, 4'b1010, 0);
        run(400, 1, 1, 4'b1001, 0);
        run(10, 1, 1, 4'b1001, 1);
        run(120, 1, 1, 4'b1001, 0);
        run(5, 1, 1, 4'b1001, 1);
        run(260, 1, 1, 4'b1001, 0);
        run(10, 1, 1, 4'b1011, 0);
        run(900, 1, 1, 4'b1111, 0);
        run(10, 1, 0, 4'b1111, 0);
        run(10, 1, 1, 4'b1001, 0);
        run(5, 1, 1, 4'b1101, 0);
        run(40, 1, 1, 4'b1111, 0);
        run(10, 1, 1, 4'b1011, 0);
        run(20, 1, 1, 4'b1111, 0);
        run(5, 1, 1, 4'b1011, 1);
        run(220, 1, 1, 4'b1011, 0);
        run(1, 1, 1, 4'b0110, 0);
        run(30, 1, 1, 4'b1001, 0);
        run(1, 0, 1, 4'b1001, 0);
        run(400, 1, 1, 4'b1001, 0);
        run(1, 1, 1, 4'b1010, 0);
        run(20, 1, 1, 4'b1001, 0);
        run(5, 1, 0, 4'b1001, 0);
        run(20, 1, 1, 4'b1001, 0);

        for (int s = 0; s < 150; s++) begin
            sp  = ($urandom_range(0, 1) == 0) ? pats[$urandom_range(0, 9)]
                                              : 4'($urandom_range(0, 15));
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(50, 400)
                                              : $urandom_range(1, 40);
            run(len, $urandom_range(0, 49) != 0, $urandom_range(0, 29) != 0,
                sp, $urandom_range(0, 9) == 0);
        end

        @(posedge clk);
        #4;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
